// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave classic Wishbone arbiter: round-robin per single-beat
// transaction, with a bus timeout that returns an error ack to the granted master.
module wb_arbiter_2m #(
  parameter int              BITS     = 32,
  parameter int              TIMEOUT  = 255,
  parameter logic [BITS-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [3:0]      m0_sel_i,
  input  logic [BITS-1:0] m0_adr_i,
  input  logic [BITS-1:0] m0_dat_i,
  output logic            m0_ack_o,
  output logic [BITS-1:0] m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [3:0]      m1_sel_i,
  input  logic [BITS-1:0] m1_adr_i,
  input  logic [BITS-1:0] m1_dat_i,
  output logic            m1_ack_o,
  output logic [BITS-1:0] m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [3:0]      s_sel_o,
  output logic [BITS-1:0] s_adr_o,
  output logic [BITS-1:0] s_dat_o,
  input  logic            s_ack_i,
  input  logic [BITS-1:0] s_dat_i,
  output logic            timeout_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t          r_state, w_next;
  logic            r_last_gnt, w_last_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_timeout;
  logic            w_req0, w_req1;
  logic            w_sel;
  logic            w_cyc, w_stb, w_we;
  logic [3:0]      w_bsel;
  logic [BITS-1:0] w_adr, w_wdat;
  logic            w_fire, w_ack, w_to_set;
  logic [BITS-1:0] w_rdat;

  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign timeout_o = r_timeout;

  // Granted master's bus, selected once so both grant states share one datapath
  assign w_sel  = (r_state == GNT1);
  assign w_cyc  = w_sel ? m1_cyc_i : m0_cyc_i;
  assign w_stb  = w_sel ? m1_stb_i : m0_stb_i;
  assign w_we   = w_sel ? m1_we_i  : m0_we_i;
  assign w_bsel = w_sel ? m1_sel_i : m0_sel_i;
  assign w_adr  = w_sel ? m1_adr_i : m0_adr_i;
  assign w_wdat = w_sel ? m1_dat_i : m0_dat_i;

  always_comb begin
    w_next     = r_state;
    w_last_nxt = r_last_gnt;
    w_to_set   = 1'b0;
    w_fire     = 1'b0;
    w_ack      = 1'b0;
    w_rdat     = '0;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m0_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_dat_o   = '0;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_next = r_last_gnt ? GNT0 : GNT1;
        else if (w_req0)      w_next = GNT0;
        else if (w_req1)      w_next = GNT1;
      end
      GNT0, GNT1: begin
        // A master that has already dropped cyc is aborting; it gets no error ack
        w_fire  = (r_cnt == CNT_LAST) && !s_ack_i && w_cyc;
        s_cyc_o = w_cyc & ~w_fire;
        s_stb_o = w_stb & ~w_fire;
        s_we_o  = w_we;
        s_sel_o = w_bsel;
        s_adr_o = w_adr;
        s_dat_o = w_wdat;
        w_ack   = s_ack_i | w_fire;
        w_rdat  = w_fire ? ERR_DATA : s_dat_i;
        if (s_ack_i) begin
          w_next     = IDLE;
          w_last_nxt = w_sel;
        end else if (!w_cyc) begin
          w_next = IDLE;
        end else if (w_fire) begin
          w_next     = IDLE;
          w_last_nxt = w_sel;
          w_to_set   = 1'b1;
        end
        if (w_sel) begin
          m1_ack_o = w_ack;
          m1_dat_o = w_rdat;
        end else begin
          m0_ack_o = w_ack;
          m0_dat_o = w_rdat;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_last_gnt <= w_last_nxt;
      // Counter only runs while a grant persists; any exit or entry clears it
      if (r_state != IDLE && w_next == r_state) r_cnt <= r_cnt + 1'b1;
      else                                      r_cnt <= '0;
      if (w_to_set) r_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Scoreboard bench for wb_arbiter_2m: directed master requests, a latency-programmable
// slave, and a negedge monitor that checks every master ack against expected queues.
module tb_wb_arbiter_2m;
  localparam int BITS = 32;
  localparam int TO   = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m1_ack_o, s_cyc_o, s_stb_o, s_we_o, s_ack_i, timeout_o;

  wb_arbiter_2m #(.BITS(BITS), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic we; logic [31:0] adr; logic [31:0] wdat; logic [3:0] sel; int abort_after;
  } req_t;
  typedef struct {
    logic err; logic we; logic [31:0] adr; logic [31:0] wdat; logic [31:0] rdat; logic [3:0] sel;
  } exp_t;

  req_t rq0[$], rq1[$];
  exp_t ex0[$], ex1[$];
  int   ord[$];
  int   n_chk = 0, n_err = 0;
  int   lat = -1;
  int   scnt = 0;
  logic slv_act = 1'b0;
  logic ack0_seen = 1'b0, ack1_seen = 1'b0;
  logic b0 = 1'b0, b1 = 1'b0;
  int   c0 = 0, c1 = 0;
  req_t r0, r1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Master drivers: raise a queued request, drop it on ack or after abort_after cycles
  always @(posedge clk_i) begin : drv0
    #1;
    if (b0) begin
      c0++;
      if (ack0_seen || (r0.abort_after > 0 && c0 >= r0.abort_after)) begin
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; b0 = 1'b0;
      end
    end
    if (!b0 && rq0.size() > 0) begin
      r0 = rq0.pop_front();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = r0.we;
      m0_sel_i = r0.sel; m0_adr_i = r0.adr; m0_dat_i = r0.wdat;
      b0 = 1'b1; c0 = 0;
    end
  end

  always @(posedge clk_i) begin : drv1
    #1;
    if (b1) begin
      c1++;
      if (ack1_seen || (r1.abort_after > 0 && c1 >= r1.abort_after)) begin
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; b1 = 1'b0;
      end
    end
    if (!b1 && rq1.size() > 0) begin
      r1 = rq1.pop_front();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = r1.we;
      m1_sel_i = r1.sel; m1_adr_i = r1.adr; m1_dat_i = r1.wdat;
      b1 = 1'b1; c1 = 0;
    end
  end

  // Slave: acks `lat` cycles after strobe is first seen; lat<=0 means never ack
  always @(posedge clk_i) begin : slave
    #1;
    if (slv_act) scnt++;
    else         scnt = 0;
    s_ack_i = (lat > 0) && (scnt == lat);
  end

  function automatic void scb(input int m);
    exp_t e;
    logic ok;
    logic [31:0] dat, odat;
    logic oack;
    dat  = (m == 0) ? m0_dat_o : m1_dat_o;
    odat = (m == 0) ? m1_dat_o : m0_dat_o;
    oack = (m == 0) ? m1_ack_o : m0_ack_o;
    ok   = (m == 0) ? (ex0.size() > 0) : (ex1.size() > 0);
    chk($sformatf("m%0d ack expected", m), {31'd0, ok}, 32'd1);
    chk("ack order", m, (ord.size() > 0) ? ord.pop_front() : -1);
    if (!ok) return;
    e = (m == 0) ? ex0.pop_front() : ex1.pop_front();
    chk($sformatf("m%0d rdata", m), dat, e.err ? ERR : e.rdat);
    chk("other ack", {31'd0, oack}, 32'd0);
    chk("other dat", odat, 32'd0);
    if (e.err) begin
      chk("timeout s_cyc", {31'd0, s_cyc_o | s_stb_o}, 32'd0);
    end else begin
      chk("s_cyc/stb", {30'd0, s_cyc_o, s_stb_o}, 32'd3);
      chk("s_adr", s_adr_o, e.adr);
      chk("s_we", {31'd0, s_we_o}, {31'd0, e.we});
      chk("s_sel", {28'd0, s_sel_o}, {28'd0, e.sel});
      if (e.we) chk("s_dat", s_dat_o, e.wdat);
    end
  endfunction

  always @(negedge clk_i) begin : monitor
    ack0_seen = m0_ack_o;
    ack1_seen = m1_ack_o;
    slv_act   = s_cyc_o & s_stb_o & ~s_ack_i;
    if (m0_ack_o && m1_ack_o) chk("both acks", 32'd1, {31'd0, m0_ack_o & ~m1_ack_o});
    else if (m0_ack_o) scb(0);
    else if (m1_ack_o) scb(1);
  end

  task automatic issue(input int m, input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                       input logic [3:0] sel, input int abort_after, input logic err);
    req_t r;
    exp_t e;
    r.we = we; r.adr = adr; r.wdat = wdat; r.sel = sel; r.abort_after = abort_after;
    e.err = err; e.we = we; e.adr = adr; e.wdat = wdat; e.rdat = s_dat_i; e.sel = sel;
    if (m == 0) rq0.push_back(r); else rq1.push_back(r);
    if (abort_after == 0) begin
      if (m == 0) ex0.push_back(e); else ex1.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || b0 || b1 || ex0.size() > 0 || ex1.size() > 0)
           && n < budget) begin
      @(negedge clk_i); n++;
    end
    chk("drain within budget", {31'd0, n < budget}, 32'd1);
    @(negedge clk_i);
  endtask

  task automatic wait_high(input string name, ref logic sig);
    int n = 0;
    while (sig !== 1'b1 && n < 40) begin @(negedge clk_i); n++; end
    chk(name, {31'd0, sig}, 32'd1);
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    rst_i = 1'b1; s_ack_i = 1'b0; s_dat_i = '0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    repeat (3) @(negedge clk_i);
    chk("rst s_cyc/stb/we", {29'd0, s_cyc_o, s_stb_o, s_we_o}, 32'd0);
    chk("rst s_sel", {28'd0, s_sel_o}, 32'd0);
    chk("rst s_adr", s_adr_o, 32'd0);
    chk("rst s_dat", s_dat_o, 32'd0);
    chk("rst acks", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    chk("rst m0_dat", m0_dat_o, 32'd0);
    chk("rst m1_dat", m1_dat_o, 32'd0);
    chk("rst timeout", {31'd0, timeout_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // single m0 read, slave latency 2
    lat = 2; s_dat_i = 32'h1234_5678;
    ord.push_back(0);
    issue(0, 1'b0, 32'h3000_0004, 32'd0, 4'hF, 0, 1'b0);
    wait_high("t1 m0 req", m0_cyc_i);
    chk("t1 stb not in req cycle", {31'd0, s_stb_o}, 32'd0);
    @(negedge clk_i); chk("t1 stb one cycle later", {31'd0, s_stb_o}, 32'd1);
    @(negedge clk_i); chk("t1 no early ack", {31'd0, m0_ack_o}, 32'd0);
    @(negedge clk_i); chk("t1 ack with slave ack", {30'd0, m0_ack_o, s_ack_i}, 32'd3);
    wait_idle(40);

    // simultaneous contention after reset alternates 0,1,0,1,...
    pulse_reset();
    lat = 1; s_dat_i = 32'hCAFE_0001;
    for (int i = 0; i < 3; i++) begin
      issue(0, 1'b0, 32'h100 + 32'(i), 32'd0, 4'hF, 0, 1'b0);
      issue(1, 1'b0, 32'h200 + 32'(i), 32'd0, 4'hF, 0, 1'b0);
      ord.push_back(0); ord.push_back(1);
    end
    wait_idle(100);

    // m1 write passthrough
    s_dat_i = 32'h0000_0000;
    ord.push_back(1);
    issue(1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'b0011, 0, 1'b0);
    wait_idle(40);

    // slave never acks -> error ack on the TIMEOUT-th granted cycle
    lat = -1; s_dat_i = 32'h1111_2222;
    ord.push_back(0);
    issue(0, 1'b0, 32'h2000, 32'd0, 4'hF, 0, 1'b1);
    wait_high("t4 granted", s_cyc_o);
    n = 0;
    while (!m0_ack_o && n < 20) begin @(negedge clk_i); n++; end
    chk("t4 timeout cycle", n, TO - 1);
    @(negedge clk_i); chk("t4 timeout_o set", {31'd0, timeout_o}, 32'd1);
    wait_idle(40);
    lat = 1; s_dat_i = 32'h3333_4444;
    ord.push_back(1);
    issue(1, 1'b0, 32'h44, 32'd0, 4'hF, 0, 1'b0);
    wait_idle(40);
    chk("t4 timeout_o sticky", {31'd0, timeout_o}, 32'd1);

    // m1 aborts; m0 then served with ack landing on the last counted cycle
    lat = 3; s_dat_i = 32'h5555_AAAA;
    issue(1, 1'b0, 32'h80, 32'd0, 4'hF, 2, 1'b0);
    @(negedge clk_i);
    ord.push_back(0);
    issue(0, 1'b0, 32'h90, 32'd0, 4'hF, 0, 1'b0);
    wait_high("t5 m1 req", m1_cyc_i);
    n = 0;
    while (m1_cyc_i && n < 20) begin @(negedge clk_i); n++; end
    @(negedge clk_i); chk("t5 idle after abort", {31'd0, s_cyc_o}, 32'd0);
    @(negedge clk_i); chk("t5 m0 granted adr", s_adr_o, 32'h90);
    wait_idle(40);
    chk("t5 timeout_o sticky", {31'd0, timeout_o}, 32'd1);

    // reset while m1 is waiting; after reset the tie goes to m0
    lat = -1; s_dat_i = 32'h600D_600D;
    issue(1, 1'b0, 32'hA0, 32'd0, 4'hF, 0, 1'b0);
    wait_high("t6 m1 granted", s_cyc_o);
    chk("t6 m1 granted adr", s_adr_o, 32'hA0);
    rst_i = 1'b1;
    issue(0, 1'b0, 32'hB0, 32'd0, 4'hF, 0, 1'b0);
    ord.push_back(0); ord.push_back(1);
    @(negedge clk_i);
    chk("t6 s_cyc after reset", {31'd0, s_cyc_o}, 32'd0);
    chk("t6 timeout_o cleared", {31'd0, timeout_o}, 32'd0);
    rst_i = 1'b0; lat = 1;
    @(negedge clk_i); chk("t6 tie to m0", s_adr_o, 32'hB0);
    wait_idle(60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
